mtf_encoder: RTL and testbench

- Move-to-front stage directly downstream of the BWT block.
- Reads the BWT output string byte-by-byte from the BWT result memory and replaces each byte with its current index in a 256-entry recency list. Writes the resulting index stream to a second memory for the entropy coder.
- Handshake style matches the BWT stage: a `CS` enable, a `flag` done indication, and separate read/write addresses.

---
 rtl/mtf_pkg.sv | 16 +
 rtl/mtf_encoder_if.sv | 27 ++
 rtl/mtf_table.sv | 33 +++
 rtl/mtf_encoder.sv | 115 +++++++++++
 tb/tb_mtf_encoder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mtf_pkg.sv
// Shared types and constants for the move-to-front stage.
package mtf_pkg;

   localparam int ALPHABET = 256;
   localparam int SYM_W    = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LOAD   = 3'd2,
      SEARCH = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5
   } mtf_state_t;

endpackage

// File: rtl/mtf_encoder_if.sv
// Memory-side handshake of the MTF stage: enable, length, BWT read port, MTF write port, done.
interface mtf_encoder_if #(
   parameter int len_addr = 10
) ();
   import mtf_pkg::*;

   logic                  CS;
   logic [len_addr-1:0]   len_str;
   logic [SYM_W-1:0]      din;
   logic [len_addr-1:0]   addr;
   logic [len_addr-1:0]   addr1;
   logic [SYM_W-1:0]      dout;
   logic                  ren;
   logic                  wen;
   logic                  flag;

   modport master (
      output CS, len_str, din,
      input  addr, addr1, dout, ren, wen, flag
   );

   modport slave (
      input  CS, len_str, din,
      output addr, addr1, dout, ren, wen, flag
   );

endinterface

// File: rtl/mtf_table.sv
// 256-entry recency list: identity load, compare one entry against a symbol, front-move shift.
module mtf_table
   import mtf_pkg::*;
(
   input  logic             clk,
   input  logic             init,
   input  logic             update,
   input  logic [SYM_W-1:0] idx,
   input  logic [SYM_W-1:0] sym,
   output logic             match
);

   logic [SYM_W-1:0] r_tbl [ALPHABET];

   // Identity load on start; on update entries 0..idx-1 move up one slot and sym lands at the front
   always_ff @(posedge clk) begin
      if (init) begin
         for (int unsigned j = 0; j < ALPHABET; j++) begin
            r_tbl[SYM_W'(j)] <= SYM_W'(j);
         end
      end else if (update) begin
         r_tbl[0] <= sym;
         for (int unsigned j = 1; j < ALPHABET; j++) begin
            if (j <= 32'(idx)) begin
               r_tbl[SYM_W'(j)] <= r_tbl[SYM_W'(j - 1)];
            end
         end
      end
   end

   assign match = (r_tbl[idx] == sym);

endmodule

// File: rtl/mtf_encoder.sv
// Move-to-front encoder: reads BWT bytes, emits each byte's recency index, then raises done.
module mtf_encoder
   import mtf_pkg::*;
#(
   parameter int len_addr    = 10,
   parameter int max_len_str = 1024
) (
   input  logic          clk,
   input  logic          reset,
   mtf_encoder_if.slave  bus
);

   // One extra bit so i can reach len without wrapping at the largest length
   localparam int              CNT_W   = len_addr + 1;
   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(max_len_str - 1);

   mtf_state_t       r_state;
   mtf_state_t       w_next;
   logic [CNT_W-1:0] r_i;
   logic [CNT_W-1:0] r_len;
   logic [SYM_W-1:0] r_sym;
   logic [SYM_W-1:0] r_idx;
   logic [CNT_W-1:0] w_len_in;
   logic             w_more;
   logic             w_match;
   logic             w_init;
   logic             w_update;

   assign w_len_in = ({1'b0, bus.len_str} > LEN_MAX) ? LEN_MAX : {1'b0, bus.len_str};
   assign w_more   = (r_i < r_len);
   assign w_init   = bus.CS && (r_state == IDLE);
   assign w_update = bus.CS && (r_state == WRITE);

   mtf_table u_table (
      .clk    (clk),
      .init   (w_init),
      .update (w_update),
      .idx    (r_idx),
      .sym    (r_sym),
      .match  (w_match)
   );

   // State register; CS=0 freezes the machine
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else if (bus.CS) begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (w_len_in == '0) ? DONE : FETCH;
         FETCH:   w_next = w_more ? LOAD : DONE;
         LOAD:    w_next = SEARCH;
         SEARCH:  w_next = w_match ? WRITE : SEARCH;
         WRITE:   w_next = FETCH;
         DONE:    w_next = DONE;
         default: w_next = IDLE;
      endcase
   end

   // Symbol counter, latched length, captured symbol and search index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_i   <= '0;
         r_len <= '0;
         r_sym <= '0;
         r_idx <= '0;
      end else if (bus.CS) begin
         case (r_state)
            IDLE: begin
               r_i   <= '0;
               r_len <= w_len_in;
            end
            LOAD: begin
               r_sym <= bus.din;
               r_idx <= '0;
            end
            SEARCH: begin
               if (!w_match) begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            WRITE: begin
               r_i <= r_i + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Memory-port and done outputs decoded from the current state
   always_comb begin
      bus.ren   = 1'b0;
      bus.wen   = 1'b0;
      bus.flag  = 1'b0;
      bus.dout  = '0;
      bus.addr  = r_i[len_addr-1:0];
      bus.addr1 = r_i[len_addr-1:0];
      case (r_state)
         FETCH: bus.ren  = w_more;
         WRITE: begin
            bus.wen  = 1'b1;
            bus.dout = r_idx;
         end
         DONE:  bus.flag = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mtf_encoder.sv
// Randomized bench for mtf_encoder against a queue-based move-to-front reference.
module tb_mtf_encoder;

   localparam int LA = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   mtf_encoder_if #(.len_addr(LA)) bus ();

   mtf_encoder #(.len_addr(LA), .max_len_str(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // BWT result memory: registered read, data one cycle after addr
   logic [7:0] mem_in [1024];
   always @(posedge clk) begin
      if (bus.ren) bus.din <= mem_in[bus.addr];
   end

   int n_checks = 0;
   int n_fail   = 0;
   int ncyc     = 0;
   int ren_cnt  = 0;
   int flag_cyc = -1;
   int wr_addr[$];
   int wr_dout[$];
   int wr_cyc[$];
   int exp_idx[$];

   // Output-side monitor sampled on the falling edge
   always @(negedge clk) begin
      ncyc++;
      if (bus.wen === 1'b1) begin
         wr_addr.push_back(int'(bus.addr1));
         wr_dout.push_back(int'(bus.dout));
         wr_cyc.push_back(ncyc);
      end
      if (bus.ren === 1'b1) ren_cnt++;
      if (bus.flag === 1'b1 && flag_cyc < 0) flag_cyc = ncyc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: recency list as a queue, index lookup then move the symbol to the front
   function automatic void mtf_model(input int n);
      int lst[$];
      int pos;
      int sym;
      exp_idx.delete();
      for (int k = 0; k < 256; k++) lst.push_back(k);
      for (int k = 0; k < n; k++) begin
         sym = int'(mem_in[k]);
         pos = -1;
         foreach (lst[m]) if (pos < 0 && lst[m] == sym) pos = m;
         exp_idx.push_back(pos);
         lst.delete(pos);
         lst.push_front(sym);
      end
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, ".flag"},  32'(bus.flag),  0);
      check({tag, ".ren"},   32'(bus.ren),   0);
      check({tag, ".wen"},   32'(bus.wen),   0);
      check({tag, ".dout"},  32'(bus.dout),  0);
      check({tag, ".addr"},  32'(bus.addr),  0);
      check({tag, ".addr1"}, 32'(bus.addr1), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      bus.CS = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
   endtask

   // mode 0: clean run; 1: CS dropped in FETCH of symbol 1 and SEARCH of symbol 2;
   // 2: reset asserted during SEARCH of symbol 1, run abandoned
   task automatic run(input string name, input int n, input int mode);
      int t0;
      int seen;
      int budget;
      int prev;
      int nw;
      mtf_model(n);
      do_reset();
      bus.len_str = LA'(n);
      @(negedge clk);
      #1;
      wr_addr.delete();
      wr_dout.delete();
      wr_cyc.delete();
      ren_cnt  = 0;
      flag_cyc = -1;
      t0       = ncyc;
      budget   = n * 260 + 100;
      bus.CS   = 1'b1;
      if (mode != 0) begin
         seen = 0;
         while (seen < 2 && ncyc - t0 < budget) begin
            @(negedge clk);
            if (bus.ren) seen++;
         end
         if (mode == 1) begin
            #1 bus.CS = 1'b0;
            repeat (10) @(negedge clk);
            #1 bus.CS = 1'b1;
            while (seen < 3 && ncyc - t0 < budget) begin
               @(negedge clk);
               if (bus.ren) seen++;
            end
            repeat (2) @(negedge clk);
            #1 bus.CS = 1'b0;
            repeat (10) @(negedge clk);
            #1 bus.CS = 1'b1;
            budget += 40;
         end else begin
            repeat (2) @(negedge clk);
            #1 reset = 1'b1;
            #1 check_idle_outputs({name, ".rstnow"});
            nw = wr_addr.size();
            repeat (3) @(negedge clk);
            #1 check_idle_outputs({name, ".rsthold"});
            check({name, ".rst_nwr"}, 32'(wr_addr.size()), 32'(nw));
            check({name, ".abort_nwr"}, 32'(nw), 1);
            reset  = 1'b0;
            bus.CS = 1'b0;
            return;
         end
      end
      while (flag_cyc < 0 && ncyc - t0 < budget) @(negedge clk);
      if (flag_cyc < 0) check({name, ".timeout"}, 0, 1);
      @(negedge clk);
      check({name, ".nwr"}, 32'(wr_addr.size()), 32'(n));
      prev = t0;
      for (int k = 0; k < n && k < wr_addr.size(); k++) begin
         check($sformatf("%s.addr1_%0d", name, k), 32'(wr_addr[k]), 32'(k));
         check($sformatf("%s.dout_%0d", name, k), 32'(wr_dout[k]), 32'(exp_idx[k]));
         if (mode == 0) begin
            check($sformatf("%s.cyc_%0d", name, k), 32'(wr_cyc[k] - prev), 32'(exp_idx[k] + 4));
            prev = wr_cyc[k];
         end
      end
      if (mode == 0) begin
         check({name, ".nren"}, 32'(ren_cnt), 32'(n));
         if (n == 0) check({name, ".flagcyc"}, 32'(flag_cyc - t0), 1);
         else if (wr_cyc.size() > 0) check({name, ".flagcyc"}, 32'(flag_cyc - wr_cyc[wr_cyc.size()-1]), 2);
      end
   endtask

   initial begin
      bus.CS      = 1'b0;
      bus.len_str = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      #1 check_idle_outputs("reset");
      reset = 1'b0;

      // "bba"
      mem_in[0] = 8'h62; mem_in[1] = 8'h62; mem_in[2] = 8'h61;
      run("bba", 3, 0);
      if (wr_dout.size() == 3) begin
         check("bba.v0", 32'(wr_dout[0]), 98);
         check("bba.v1", 32'(wr_dout[1]), 0);
         check("bba.v2", 32'(wr_dout[2]), 98);
      end

      // single worst-case byte
      mem_in[0] = 8'hFF;
      run("ff", 1, 0);
      if (wr_dout.size() == 1) check("ff.v0", 32'(wr_dout[0]), 255);

      // empty string
      run("empty", 0, 0);

      // idx=1 shift leaving upper entries alone
      mem_in[0] = 8'h00; mem_in[1] = 8'h01; mem_in[2] = 8'h00; mem_in[3] = 8'h01;
      run("alt", 4, 0);
      if (wr_dout.size() == 4) check("alt.v1", 32'(wr_dout[1]), 1);

      // CS interruptions
      mem_in[0] = 8'h10; mem_in[1] = 8'h20; mem_in[2] = 8'h30; mem_in[3] = 8'h10;
      run("csdrop", 4, 1);

      // reset mid-SEARCH, then a clean rerun of the same data
      mem_in[0] = 8'h41; mem_in[1] = 8'h42; mem_in[2] = 8'h43;
      run("abort", 3, 2);
      run("rerun", 3, 0);

      // randomized runs, mixing small and full alphabets
      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(1, 24));
         for (int k = 0; k < n; k++)
            mem_in[k] = (r % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         run($sformatf("rnd%0d", r), n, (r == 3) ? 1 : 0);
      end

      // maximum length: counter must stop exactly at 1023
      for (int k = 0; k < 1023; k++) mem_in[k] = 8'($urandom_range(0, 3));
      run("maxlen", 1023, 0);

      // DONE ignores CS toggling
      begin
         int nw;
         nw = wr_addr.size();
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 bus.CS = ~bus.CS;
         end
         @(negedge clk);
         check("hold.flag", 32'(bus.flag), 1);
         check("hold.wen", 32'(bus.wen), 0);
         check("hold.nwr", 32'(wr_addr.size()), 32'(nw));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
